// File: rtl/serial_addsub_pkg.sv
// ============================================================================
//  Module      : serial_addsub_pkg
//  Description : Shared types and constants for the bit-serial add/sub
//                controller (FSM state encoding, operation codes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

    // Controller states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Operation select captured with the operands
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : serial_addsub_pkg

`default_nettype wire

// File: rtl/addsub_bit_cell.sv
// ============================================================================
//  Module      : addsub_bit_cell
//  Description : Combinational 1-bit full adder / full subtractor. For
//                subtraction, cin/cout carry the borrow rather than a carry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_bit_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic s,
    output logic cout
);

    logic w_p;

    // Sum/difference bit is identical for add and subtract; only the
    // carry/borrow generation differs.
    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (op == OP_SUB) ? ((~a & b) | (cin & ~w_p))
                                 : (( a & b) | (cin &  w_p));

endmodule : addsub_bit_cell

`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
// ============================================================================
//  Module      : serial_addsub_ctrl
//  Description : Bit-serial add/subtract engine. Operands are accepted by
//                valid/ready, processed LSB-first one bit per clock through
//                a single addsub_bit_cell, and the W-bit result is returned
//                by valid/ready.
//  Config      : define SERIAL_ADDSUB_OVF_EN to build the two's-complement
//                overflow flag; otherwise ovf is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         ovf
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]       a_sr_q,  a_sr_d;
    logic [W-1:0]       b_sr_q,  b_sr_d;
    logic [W-1:0]       res_q,   res_d;
    logic               op_q,    op_d;
    logic               cb_q,    cb_d;

    logic               w_sum;
    logic               w_cout;
    logic               w_last;

    // Single shared arithmetic cell, fed from the operand LSBs
    addsub_bit_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (cb_q),
        .op   (op_q),
        .s    (w_sum),
        .cout (w_cout)
    );

    assign w_last = (cnt_q == C_CNT_LAST);

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            cb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cb_q    <= cb_d;
        end
    end

    // Next-state and datapath control: accept in IDLE, shift in RUN,
    // hold in DONE until the consumer takes the result
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        op_d    = op_q;
        cb_d    = cb_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    op_d    = op;
                    cb_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sr_d = {1'b0, a_sr_q[W-1:1]};
                b_sr_d = {1'b0, b_sr_q[W-1:1]};
                res_d  = {w_sum, res_q[W-1:1]};
                cb_d   = w_cout;
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign carry_out = cb_q;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow = carry into MSB XOR carry out of MSB, taken on the final bit
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_RUN && w_last) begin
            ovf_d = cb_q ^ w_cout;
        end
    end

    // Overflow flag register, held with the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule : serial_addsub_ctrl

`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
// ============================================================================
//  Module      : tb_serial_addsub_ctrl
//  Description : Self-checking bench for serial_addsub_ctrl with a result
//                scoreboard, latency checks, back-pressure and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_addsub_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic C_OVF_ON = 1'b1;
`else
    localparam logic C_OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    serial_addsub_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference: full-width arithmetic plus sign-rule overflow
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        exp_t       e;
        if (!o) begin
            t   = {1'b0, x} + {1'b0, y};
            e.v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        end else begin
            t   = {1'b0, x} - {1'b0, y};
            e.v = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
        end
        e.res = t[W-1:0];
        e.c   = t[W];
        e.v   = e.v & C_OVF_ON;
        return e;
    endfunction

    // Output monitor: pop and compare on every completed result handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            check("unexpected_out", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("result",    result,    e.res);
                check("carry_out", carry_out, e.c);
                check("ovf",       ovf,       e.v);
            end
        end
    end

    // Issue one operation, push its expectation and check W-cycle latency
    task automatic send_exp(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                            input exp_t e);
        int lat;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        sb_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check("latency", lat, W);
    endtask

    task automatic send(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        send_exp(o, x, y, model(o, x, y));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result",    result,    0);
        check("rst_carry",     carry_out, 0);
        check("rst_ovf",       ovf,       0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases with hand-derived expectations
        send_exp(1'b0, 8'h5A, 8'h33, '{res: 8'h8D, c: 1'b0, v: C_OVF_ON});
        send_exp(1'b1, 8'h10, 8'h20, '{res: 8'hF0, c: 1'b1, v: 1'b0});
        send_exp(1'b0, 8'hFF, 8'h01, '{res: 8'h00, c: 1'b1, v: 1'b0});
        send_exp(1'b1, 8'h80, 8'h01, '{res: 8'h7F, c: 1'b0, v: C_OVF_ON});

        // Random operations against the reference model
        for (int i = 0; i < 12; i++) begin
            send(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
        end

        // Back-pressure in DONE: result held, a new request is ignored
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(1'b0, 8'h12, 8'h34);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 2);
            op       = 1'b1;
            a        = 8'hAA;
            b        = 8'h55;
            check("hold_in_ready",  in_ready,  0);
            check("hold_out_valid", out_valid, 1);
            check("hold_result",    result,    8'h46);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_ghost_valid", out_valid, 0);
            check("no_ghost_ready", in_ready,  1);
        end

        // Asynchronous reset in the middle of RUN discards the operation
        @(negedge clk);
        in_valid = 1'b1;
        op       = 1'b0;
        a        = 8'h0F;
        b        = 8'h01;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready",  in_ready,  1);
        check("arst_result",    result,    0);
        check("arst_carry",     carry_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_exp(1'b0, 8'h01, 8'h01, '{res: 8'h02, c: 1'b0, v: 1'b0});

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_serial_addsub_ctrl

`default_nettype wire
